// File: rtl/weight_word_gen.sv
// Enumerates every 32-bit word of Hamming weight k in increasing numeric order,
// one word per valid/ready handshake, using Gosper's next-combination step.
module weight_word_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  k,
  output logic [31:0] word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        last,
  output logic [29:0] cnt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] last_word;
  logic [31:0] first_w;
  logic [31:0] low_w;
  logic [31:0] lowbit;
  logic [31:0] ripple;
  logic [31:0] nxt_word;
  logic [4:0]  tz;
  logic        start_ok;
  logic        start_bad;
  logic        hs;

  // Handshake: word transfers on any rising edge where out_valid and out_ready
  // are both high; out_valid is a pure function of state, never of out_ready.
  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == FIN);
  assign last      = (state == RUN) && (word == last_word);
  assign dbg_state = state;
  assign hs        = out_valid & out_ready;

  assign start_ok  = start && (k <= 6'd32);
  assign start_bad = start && (k >  6'd32);

  // First word is k ones at the LSB end; the final word is k ones at the MSB end.
  assign first_w = (k == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
  assign low_w   = (k == 6'd0)  ? 32'hFFFF_FFFF : ((32'd1 << (6'd32 - k)) - 32'd1);

  always_comb begin
    tz = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (word[i]) tz = 5'(i);
    end
  end

  assign lowbit   = word & (~word + 32'd1);
  assign ripple   = word + lowbit;
  assign nxt_word = ripple | (((ripple ^ word) >> 2) >> tz);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (hs && last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word      <= 32'd0;
      last_word <= 32'd0;
      cnt       <= 30'd0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            word      <= first_w;
            last_word <= ~low_w;
            cnt       <= 30'd0;
          end
          if (start_bad) err <= 1'b1;
        end
        RUN: begin
          if (hs) begin
            cnt <= cnt + 30'd1;
            if (!last) word <= nxt_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
